// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: ARM condition codes, CPSR flag
// positions, FSM states and the condition-evaluation helper.
package issue_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int CPSR_N_BIT = 31;
  localparam int CPSR_Z_BIT = 30;
  localparam int CPSR_C_BIT = 29;
  localparam int CPSR_V_BIT = 28;
  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 28;

  typedef enum logic {
    WAIT_READY = 1'b0,
    WAIT_DROP  = 1'b1
  } issueState_e;

  // nzcv packs the flags in CPSR order: {N, Z, C, V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    unique case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop level synchronizer with asynchronous active-low reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= d;
      stage2 <= stage1;
    end
  end

  assign q = stage2;

endmodule

// File: rtl/issue_stage.sv
// Toggle-handshake consumer from fetch feeding a small FIFO toward decode.
// Define ISSUE_COND_FILTER_EN to drop words whose ARM condition fails on CPSR.
module issue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     readyIn,
  input  logic [31:0]              dataIn,
  output logic                     triggerOut,
  input  logic [31:0]              cpsr,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         skip_count
);

  import issue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic              readyS;
  issueState_e       state, nextState;
  logic              capture;
  logic              filterPass;
  logic              push, pop;
  logic              triggerQ;
  logic [LVL_W-1:0]  levelQ;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [31:0]       headQ;
  logic [31:0]       mem [DEPTH];

  sync2 #(.WIDTH(1)) uReadySync (
    .clk   (clk),
    .reset (reset),
    .d     (readyIn),
    .q     (readyS)
  );

`ifdef ISSUE_COND_FILTER_EN
  logic [CNT_W-1:0] skipQ;

  assign filterPass = cond_pass(dataIn[COND_MSB:COND_LSB],
                                {cpsr[CPSR_N_BIT], cpsr[CPSR_Z_BIT],
                                 cpsr[CPSR_C_BIT], cpsr[CPSR_V_BIT]});

  // Rejected words still complete the handshake; only the count moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skipQ <= '0;
    end else if (capture && !filterPass && (skipQ != '1)) begin
      skipQ <= skipQ + CNT_W'(1);
    end
  end

  assign skip_count = skipQ;
`else
  logic unusedCpsr;
  assign unusedCpsr = ^cpsr;
  assign filterPass = 1'b1;
  assign skip_count = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_READY;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    capture   = 1'b0;
    unique case (state)
      WAIT_READY: begin
        if (readyS && (levelQ < LVL_W'(DEPTH))) begin
          capture   = 1'b1;
          nextState = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!readyS) nextState = WAIT_READY;
      end
      default: nextState = WAIT_READY;
    endcase
  end

  assign push = capture && filterPass && !flush;
  assign pop  = (levelQ != '0) && out_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      triggerQ <= 1'b0;
      levelQ   <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      headQ    <= '0;
    end else begin
      if (capture) triggerQ <= ~triggerQ;
      if (flush) begin
        levelQ <= '0;
        wrPtr  <= '0;
        rdPtr  <= '0;
      end else begin
        levelQ <= levelQ + LVL_W'(push) - LVL_W'(pop);
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        // Head register: bypass the incoming word when it becomes the head,
        // otherwise pre-load the next stored entry on a pop.
        if (push && ((levelQ == '0) || (pop && (levelQ == LVL_W'(1))))) begin
          headQ <= dataIn;
        end else if (pop && (levelQ > LVL_W'(1))) begin
          headQ <= mem[rdPtr + PTR_W'(1)];
        end
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by levelQ, so
  // stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= dataIn;
  end

  assign triggerOut = triggerQ;
  assign out_valid  = (levelQ != '0);
  assign out_instr  = headQ;
  assign level      = levelQ;

endmodule
